mmio_timer: RTL
===============

# mmio_timer

Memory-mapped timer/compare peripheral and a responder on the CPU data-memory bus. Sits alongside the block RAM on the same address/data/write-enable wires. It claims a small address window and answers reads with the same one-cycle latency as the RAM. Outside its window, its read data is zero, so the system ORs it with the RAM output.

## Interface
- SIZE, 14, address width (matches CPU addr_toRAM)
- BASE, 14'h3FF0, window base; low 3 address bits select the register, window = BASE..BASE+7
- PSW, 16, prescaler width

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- i_we  in  1  write enable from CPU
- i_addr  in  SIZE  byte-free word address from CPU
- i_data_in  in  32  write data from CPU
- o_data_out  out  32  registered read data
- o_irq  out  1  interrupt request (only with TIMER_IRQ_EN)

## Operation
- Hit = i_addr[SIZE-1:3] == BASE[SIZE-1:3]. Register index = i_addr[2:0].
- Registers:
  - 0 CTRL, bits [2:0]: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 1 PRESCALE, PSW bits.
  - 2 COUNT, 32 bits.
  - 3 COMPARE, 32 bits.
  - 4 STATUS: bit0 MATCH. Read returns it; writing 1 clears it; writing 0 has no effect.
  - 5–7: reserved; read 0, writes ignored.
- Writes occur when i_we && hit, at the clock edge.
- Prescaler counter pcnt (PSW bits):
  - When EN=1: if pcnt == PRESCALE then pcnt←0 and tick=1; else pcnt←pcnt+1.
  - When EN=0: pcnt←0, tick=0.
  - PRESCALE=0 gives a tick every cycle.
- On tick:
  - If COUNT == COMPARE: MATCH←1. Then COUNT←0 if AUTO_RELOAD, else COUNT←COUNT+1.
  - Otherwise COUNT←COUNT+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
- Simultaneous events:
  - CPU write to COUNT in a tick cycle: the write wins, and the tick's increment is discarded.
  - Write-1-to-clear MATCH in the cycle a match sets it: the set wins, MATCH stays 1.
  - Write to CTRL clearing EN: the tick of that same cycle still takes effect, because tick is computed from the pre-write EN.
  - Write to PRESCALE: pcnt is not reset. If pcnt already exceeds the new PRESCALE, it counts up through the wrap-around to 0 and then reaches PRESCALE.

## Timing
- Read latency is 1 cycle. o_data_out at edge N+1 reflects the register value *before* any write at edge N (read-before-write, same as RAM).
- If the address was not a hit, o_data_out = 0 on the next cycle.
- Reset values: o_data_out=0, CTRL=0, PRESCALE=0, COUNT=0, COMPARE=0xFFFFFFFF, MATCH=0, pcnt=0, o_irq=0.
- Reset mid-count: everything returns to reset values immediately (asynchronous). Counting resumes only after software sets EN.
- The bus is not held by the timer: no stall, no handshake. Every cycle is an independent access.

## Configuration
- TIMER_IRQ_EN defined:
  - o_irq port exists.
  - o_irq is a registered output equal to MATCH && IRQ_EN, i.e. one cycle after MATCH sets.
  - IRQ_EN bit is readable and writable.
- TIMER_IRQ_EN undefined:
  - o_irq port is absent.
  - CTRL bit2 reads 0, and writes to it are ignored.
  - All other behaviour is unchanged.

## Structure
- Shared package mmio_timer_pkg holds:
  - register index constants (REG_CTRL=0, REG_PRESCALE=1, REG_COUNT=2, REG_COMPARE=3, REG_STATUS=4);
  - CTRL bit positions;
  - COMPARE reset constant.
- One sub-module: timer_prescaler (pcnt, PRESCALE compare, tick output, clear on !EN).
- Register file, compare logic and read mux live in the top.

## Test plan
- Reset check: release rst, then read addresses BASE+0..7. Expect 0,0,0,0xFFFFFFFF,0,0,0,0, with data returned one cycle after each address. Reading address 0x0000 returns 0.
- Free-run: PRESCALE=3, CTRL=1, wait 40 cycles, read COUNT. Expect 10 ±1, i.e. one increment per 4 cycles.
- Match with auto-reload: PRESCALE=0, COMPARE=5, CTRL=3.
  - MATCH=1 after the 6th tick, and COUNT reads 0 then restarts.
  - Writing STATUS=1 clears MATCH; writing STATUS=0 does not.
- Wrap: COUNT=0xFFFFFFFE, COMPARE=0x10, AUTO_RELOAD=0, PRESCALE=0, EN=1. Two ticks later COUNT=0x00000000 and MATCH stays 0.
- Collisions:
  - Write COUNT=0x100 in a tick cycle: read back 0x100, not 0x101.
  - Write-1-to-clear STATUS in the match cycle: MATCH stays 1.
- IRQ (TIMER_IRQ_EN defined): CTRL=7, COMPARE=2. o_irq rises 1 cycle after MATCH. It falls the cycle after a STATUS clear, or after an IRQ_EN=0 write. Assert rst=0 mid-count: o_irq and COUNT go to 0 immediately.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register indices, CTRL bit positions and reset constants shared by the timer files
package mmio_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: CPU data-memory bus shared by the block RAM and the timer (no handshake)
interface mmio_timer_if #(
    parameter int SIZE = 14
);
    logic            i_we;
    logic [SIZE-1:0] i_addr;
    logic [31:0]     i_data_in;
    logic [31:0]     o_data_out;

    modport master (output i_we, output i_addr, output i_data_in, input o_data_out);
    modport slave  (input i_we, input i_addr, input i_data_in, output o_data_out);
endinterface

// File: rtl/mmio_timer_prescaler.sv
// timer_prescaler: counts 0..prescale and emits a one-cycle tick on the terminal value; held clear while disabled
module timer_prescaler #(
    parameter int PSW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [PSW-1:0] prescale,
    output logic           tick
);
    logic [PSW-1:0] pcnt_q, pcnt_d;

    // A lowered prescale is not applied to pcnt; it wraps through zero to reach the new terminal value
    always_comb begin
        tick   = en && (pcnt_q == prescale);
        pcnt_d = (!en || tick) ? '0 : pcnt_q + 1'b1;
    end

    // Prescaler state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pcnt_q <= '0;
        else      pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/compare peripheral on the CPU data bus; optional o_irq with macro TIMER_IRQ_EN
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int              SIZE = 14,
    parameter logic [SIZE-1:0] BASE = 14'h3FF0,
    parameter int              PSW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    mmio_timer_if.slave bus
`ifdef TIMER_IRQ_EN
    ,
    output logic        o_irq
`endif
);
`ifdef TIMER_IRQ_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

    logic [2:0]     ctrl_q, ctrl_d;
    logic [PSW-1:0] prescale_q, prescale_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    compare_q, compare_d;
    logic           match_q, match_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           hit, tick, eq;
    logic [2:0]     idx;

    assign hit = bus.i_addr[SIZE-1:3] == BASE[SIZE-1:3];
    assign idx = bus.i_addr[2:0];
    assign eq  = count_q == compare_q;

    timer_prescaler #(.PSW(PSW)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Register writes and count/match update; a CPU COUNT write overrides the tick, a match set overrides a clear
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = tick ? ((eq && ctrl_q[CTRL_AUTO_RELOAD]) ? 32'd0 : count_q + 32'd1) : count_q;
        match_d    = match_q;
        if (bus.i_we && hit) begin
            if (idx == REG_CTRL)     ctrl_d     = bus.i_data_in[2:0] & CTRL_WMASK;
            if (idx == REG_PRESCALE) prescale_d = bus.i_data_in[PSW-1:0];
            if (idx == REG_COUNT)    count_d    = bus.i_data_in;
            if (idx == REG_COMPARE)  compare_d  = bus.i_data_in;
            if (idx == REG_STATUS && bus.i_data_in[0]) match_d = 1'b0;
        end
        if (tick && eq) match_d = 1'b1;
    end

    // Read mux sampling pre-write register values; zero outside the window so it can be ORed with RAM data
    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (idx)
                REG_CTRL:     rdata_d = 32'(ctrl_q);
                REG_PRESCALE: rdata_d = 32'(prescale_q);
                REG_COUNT:    rdata_d = count_q;
                REG_COMPARE:  rdata_d = compare_q;
                REG_STATUS:   rdata_d = 32'(match_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    // Register file and read-data state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= COMPARE_RST;
            match_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.o_data_out = rdata_q;

`ifdef TIMER_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = match_q && ctrl_q[CTRL_IRQ_EN];

    // Interrupt follows MATCH && IRQ_EN one cycle late
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_q <= 1'b0;
        else      irq_q <= irq_d;
    end

    assign o_irq = irq_q;
`endif
endmodule
